ioshim_ioep_hub: RTL and testbench

- Parametrised IO-endpoint responder for the ioshim_cpu IO port. It generalises the single hard-wired endpoint into NUM_CH byte channels.
- Each channel has a TX FIFO (CPU to external) and an RX FIFO (external to CPU).
- Each channel is reached through two endpoint numbers: a data endpoint and a status endpoint.
- Sits between the CPU io_* port and peripheral byte streams. Responses follow the one-cycle-registered timing the CPU expects.

---
 rtl/ioshim_ioep_hub.sv | 166 ++++++++++++++++
 tb/tb_ioshim_ioep_hub.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioshim_ioep_hub.sv
// IO-endpoint hub: NUM_CH byte channels behind the ioshim_cpu IO port.
// Each channel owns a TX FIFO (CPU to peripheral) and an RX FIFO (peripheral to CPU).
module ioshim_ioep_hub #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int EPBASE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_en,
    input  logic [4:0]            io_epnum,
    input  logic [7:0]            io_dout1,
    input  logic [7:0]            io_dout2,
    input  logic [15:0]           io_ab_dout,
    output logic [7:0]            io_din,
    output logic                  io_wreg,
    output logic                  io_wa,
    output logic                  io_wb,
    output logic [15:0]           io_ab_din,
    output logic [8*NUM_CH-1:0]   tx_data,
    output logic [NUM_CH-1:0]     tx_valid,
    input  logic [NUM_CH-1:0]     tx_ready,
    input  logic [8*NUM_CH-1:0]   rx_data,
    input  logic [NUM_CH-1:0]     rx_valid,
    output logic [NUM_CH-1:0]     rx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NUM_CH-1:0]         data_hit, stat_hit;
    logic [NUM_CH-1:0]         tx_empty, tx_full, rx_empty, rx_full;
    logic [NUM_CH-1:0]         ovf, udf, ovf_set, udf_set;
    logic [NUM_CH-1:0][CW-1:0] tx_count, rx_count;
    logic [NUM_CH-1:0][7:0]    rx_head;

    logic [7:0]  din_nxt;
    logic        wreg_nxt, wa_nxt;
    logic [15:0] ab_nxt;

    wire unused_inputs = &{1'b0, io_ab_dout, io_dout1[6:2]};

    assign io_wb = 1'b0;

    always_comb begin
        data_hit = '0;
        stat_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            data_hit[c] = io_en && (io_epnum == 5'(EPBASE + 2 * c));
            stat_hit[c] = io_en && (io_epnum == 5'(EPBASE + 2 * c + 1));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]    tx_mem [DEPTH];
        logic [7:0]    rx_mem [DEPTH];
        logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
        logic [CW-1:0] tx_cnt, rx_cnt;
        logic          tx_push, tx_pop, rx_push, rx_pop;

        // Full/empty come from pre-edge counts, so a push to a full FIFO is
        // rejected even when the other side drains it in the same cycle.
        assign tx_empty[c] = (tx_cnt == '0);
        assign tx_full[c]  = (tx_cnt == CW'(DEPTH));
        assign rx_empty[c] = (rx_cnt == '0);
        assign rx_full[c]  = (rx_cnt == CW'(DEPTH));

        assign tx_push = data_hit[c] & io_dout1[0] & ~tx_full[c];
        assign tx_pop  = tx_valid[c] & tx_ready[c];
        assign rx_push = rx_valid[c] & rx_ready[c];
        assign rx_pop  = data_hit[c] & io_dout1[1] & ~rx_empty[c];

        assign ovf_set[c] = data_hit[c] & io_dout1[0] & tx_full[c];
        assign udf_set[c] = data_hit[c] & io_dout1[1] & rx_empty[c];

        assign tx_valid[c]        = ~tx_empty[c];
        assign rx_ready[c]        = ~rx_full[c];
        assign tx_data[8*c +: 8]  = tx_mem[tx_rd];
        assign rx_head[c]         = rx_mem[rx_rd];
        assign tx_count[c]        = tx_cnt;
        assign rx_count[c]        = rx_cnt;

        // NOTE: FIFO storage carries no reset; the counts alone define which
        // entries are live, and leaving the arrays unreset lets them map to RAM.
        always_ff @(posedge clk) begin
            if (tx_push) tx_mem[tx_wr] <= io_dout2;
            if (rx_push) rx_mem[rx_wr] <= rx_data[8*c +: 8];
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else begin
                if (tx_push) tx_wr <= tx_wr + AW'(1);
                if (tx_pop)  tx_rd <= tx_rd + AW'(1);
                if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
                else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CW'(1);

                if (rx_push) rx_wr <= rx_wr + AW'(1);
                if (rx_pop)  rx_rd <= rx_rd + AW'(1);
                if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
                else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CW'(1);
            end
        end
    end

    // Sticky error flags: a set in the same cycle as a status clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= '0;
            udf <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (stat_hit[c] && io_dout1[7]) begin
                    ovf[c] <= 1'b0;
                    udf[c] <= 1'b0;
                end
                if (ovf_set[c]) ovf[c] <= 1'b1;
                if (udf_set[c]) udf[c] <= 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        din_nxt  = '0;
        wreg_nxt = 1'b0;
        wa_nxt   = 1'b0;
        ab_nxt   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (data_hit[c] && io_dout1[1]) begin
                wreg_nxt = 1'b1;
                din_nxt  = rx_empty[c] ? 8'h00 : rx_head[c];
            end
            if (stat_hit[c]) begin
                wreg_nxt = 1'b1;
                wa_nxt   = 1'b1;
                din_nxt  = {ovf[c], udf[c], rx_full[c], rx_empty[c],
                            tx_full[c], tx_empty[c], 2'b00};
                ab_nxt   = {8'(rx_count[c]), 8'(tx_count[c])};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_din    <= '0;
            io_wreg   <= 1'b0;
            io_wa     <= 1'b0;
            io_ab_din <= '0;
        end else begin
            io_din    <= din_nxt;
            io_wreg   <= wreg_nxt;
            io_wa     <= wa_nxt;
            io_ab_din <= ab_nxt;
        end
    end

endmodule

// File: tb/tb_ioshim_ioep_hub.sv
// Self-checking bench for ioshim_ioep_hub: directed scenarios plus randomized
// traffic, all compared against a queue-based channel model.
module tb_ioshim_ioep_hub;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int EPBASE = 1;

    typedef logic [7:0] byte_q_t[$];

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 io_en;
    logic [4:0]           io_epnum;
    logic [7:0]           io_dout1, io_dout2;
    logic [15:0]          io_ab_dout;
    logic [7:0]           io_din;
    logic                 io_wreg, io_wa, io_wb;
    logic [15:0]          io_ab_din;
    logic [8*NUM_CH-1:0]  tx_data;
    logic [NUM_CH-1:0]    tx_valid, tx_ready;
    logic [8*NUM_CH-1:0]  rx_data;
    logic [NUM_CH-1:0]    rx_valid, rx_ready;

    int checks   = 0;
    int failures = 0;

    byte_q_t txq [NUM_CH];
    byte_q_t rxq [NUM_CH];
    bit      ovf_m [NUM_CH];
    bit      udf_m [NUM_CH];

    ioshim_ioep_hub #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .EPBASE(EPBASE)) dut (
        .clk(clk), .reset(reset),
        .io_en(io_en), .io_epnum(io_epnum), .io_dout1(io_dout1), .io_dout2(io_dout2),
        .io_ab_dout(io_ab_dout),
        .io_din(io_din), .io_wreg(io_wreg), .io_wa(io_wa), .io_wb(io_wb),
        .io_ab_din(io_ab_din),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < NUM_CH; k++) begin
            txq[k].delete();
            rxq[k].delete();
            ovf_m[k] = 1'b0;
            udf_m[k] = 1'b0;
        end
    endtask

    // One CPU/peripheral cycle: drive, advance the model, clock, compare.
    task automatic step(input bit en, input logic [4:0] ep, input logic [7:0] c1,
                        input logic [7:0] c2, input string tag);
        int         ch;
        bit         st;
        logic [7:0] e_din;
        logic       e_wreg, e_wa;
        logic [15:0] e_ab;
        io_en      = en;
        io_epnum   = ep;
        io_dout1   = c1;
        io_dout2   = c2;
        io_ab_dout = 16'($urandom);
        ch = -1;
        st = 1'b0;
        if (en && int'(ep) >= EPBASE && int'(ep) < EPBASE + 2 * NUM_CH) begin
            ch = (int'(ep) - EPBASE) / 2;
            st = ((int'(ep) - EPBASE) % 2) == 1;
        end
        e_din = 8'h00; e_wreg = 1'b0; e_wa = 1'b0; e_ab = 16'h0000;
        if (ch >= 0 && st) begin
            e_wreg = 1'b1;
            e_wa   = 1'b1;
            e_din  = {ovf_m[ch], udf_m[ch], rxq[ch].size() == DEPTH, rxq[ch].size() == 0,
                      txq[ch].size() == DEPTH, txq[ch].size() == 0, 2'b00};
            e_ab   = {8'(rxq[ch].size()), 8'(txq[ch].size())};
        end else if (ch >= 0 && c1[1]) begin
            e_wreg = 1'b1;
            e_din  = (rxq[ch].size() > 0) ? rxq[ch][0] : 8'h00;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            bit tx_was_full  = txq[k].size() == DEPTH;
            bit rx_was_full  = rxq[k].size() == DEPTH;
            bit rx_was_empty = rxq[k].size() == 0;
            bit cpu_data     = (ch == k) && !st;
            if (tx_ready[k] && txq[k].size() > 0) void'(txq[k].pop_front());
            if (cpu_data && c1[0] && !tx_was_full) txq[k].push_back(c2);
            if (cpu_data && c1[1] && !rx_was_empty) void'(rxq[k].pop_front());
            if (rx_valid[k] && !rx_was_full) rxq[k].push_back(rx_data[8*k +: 8]);
            if ((ch == k) && st && c1[7]) begin
                ovf_m[k] = 1'b0;
                udf_m[k] = 1'b0;
            end
            if (cpu_data && c1[0] && tx_was_full) ovf_m[k] = 1'b1;
            if (cpu_data && c1[1] && rx_was_empty) udf_m[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (io_din !== e_din) begin
            failures++;
            $display("FAIL %s io_din got=%h exp=%h", tag, io_din, e_din);
        end
        checks++;
        if (io_wreg !== e_wreg) begin
            failures++;
            $display("FAIL %s io_wreg got=%b exp=%b", tag, io_wreg, e_wreg);
        end
        checks++;
        if (io_wa !== e_wa || io_wb !== 1'b0) begin
            failures++;
            $display("FAIL %s io_wa/io_wb got=%b/%b exp=%b/0", tag, io_wa, io_wb, e_wa);
        end
        checks++;
        if (io_ab_din !== e_ab) begin
            failures++;
            $display("FAIL %s io_ab_din got=%h exp=%h", tag, io_ab_din, e_ab);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (tx_valid[k] !== (txq[k].size() > 0)) begin
                failures++;
                $display("FAIL %s tx_valid[%0d] got=%b exp=%b", tag, k, tx_valid[k], txq[k].size() > 0);
            end
            if (txq[k].size() > 0) begin
                checks++;
                if (tx_data[8*k +: 8] !== txq[k][0]) begin
                    failures++;
                    $display("FAIL %s tx_data[%0d] got=%h exp=%h", tag, k, tx_data[8*k +: 8], txq[k][0]);
                end
            end
            checks++;
            if (rx_ready[k] !== (rxq[k].size() < DEPTH)) begin
                failures++;
                $display("FAIL %s rx_ready[%0d] got=%b exp=%b", tag, k, rx_ready[k], rxq[k].size() < DEPTH);
            end
        end
        io_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({io_din, io_wreg, io_wa, io_wb, io_ab_din} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b/%h exp=0", io_din, io_wreg, io_wa, io_wb, io_ab_din);
        end
        checks++;
        if (tx_valid !== 4'h0 || rx_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_stream got tx_valid=%h rx_ready=%h exp 0/F", tx_valid, rx_ready);
        end
        reset = 1'b0;
        step(1'b1, 5'd2, 8'h00, 8'h00, "reset_status");
        step(1'b0, 5'd0, 8'h00, 8'h00, "idle_after_status");
    endtask

    task automatic test_tx_stream();
        tx_ready = '0;
        step(1'b1, 5'd1, 8'h01, 8'hA5, "tx_push_a5");
        step(1'b1, 5'd1, 8'h01, 8'h3C, "tx_push_3c");
        tx_ready[0] = 1'b1;
        repeat (3) step(1'b0, 5'd0, 8'h00, 8'h00, "tx_drain");
        tx_ready = '0;
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < 9; i++) step(1'b1, 5'd3, 8'h01, 8'(i), "tx_fill");
        step(1'b1, 5'd4, 8'h00, 8'h00, "ovf_status");
        step(1'b1, 5'd4, 8'h80, 8'h00, "ovf_status_clear");
        step(1'b1, 5'd4, 8'h00, 8'h00, "ovf_status_after_clear");
        tx_ready[1] = 1'b1;
        step(1'b1, 5'd3, 8'h01, 8'h77, "push_full_while_pop");
        tx_ready[1] = 1'b0;
        step(1'b1, 5'd4, 8'h00, 8'h00, "ovf_status_simul");
        tx_ready = '1;
        repeat (DEPTH) step(1'b0, 5'd0, 8'h00, 8'h00, "tx_drain_all");
        tx_ready = '0;
        step(1'b1, 5'd4, 8'h80, 8'h00, "ovf_final_clear");
    endtask

    task automatic test_rx_underflow();
        rx_valid[2] = 1'b1;
        rx_data[16 +: 8] = 8'h11;
        step(1'b0, 5'd0, 8'h00, 8'h00, "rx_ext_push");
        rx_valid = '0;
        step(1'b1, 5'd5, 8'h02, 8'h00, "rx_pop_11");
        step(1'b1, 5'd5, 8'h02, 8'h00, "rx_pop_empty");
        step(1'b1, 5'd6, 8'h00, 8'h00, "udf_status");
        step(1'b1, 5'd6, 8'h80, 8'h00, "udf_clear");
        rx_valid[2] = 1'b1;
        rx_data[16 +: 8] = 8'h42;
        step(1'b1, 5'd5, 8'h02, 8'h00, "pop_empty_while_push");
        rx_valid = '0;
        step(1'b1, 5'd6, 8'h00, 8'h00, "udf_status_simul");
        step(1'b1, 5'd5, 8'h03, 8'h99, "pop_and_push_both_bits");
    endtask

    task automatic test_rx_wrap();
        rx_valid[3] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data[24 +: 8] = 8'h50 + 8'(i);
            step(1'b0, 5'd0, 8'h00, 8'h00, "rx_fill");
        end
        rx_data[24 +: 8] = 8'hEE;
        step(1'b1, 5'd7, 8'h02, 8'h00, "pop_full_while_push");
        step(1'b1, 5'd8, 8'h00, 8'h00, "rx_status_after_simul");
        for (int i = 0; i < 20; i++) begin
            rx_data[24 +: 8] = 8'hC0 + 8'(i);
            step(1'b1, 5'd7, 8'h02, 8'h00, "rx_pair");
        end
        rx_valid = '0;
        while (rxq[3].size() > 0) step(1'b1, 5'd7, 8'h02, 8'h00, "rx_drain");
    endtask

    task automatic test_unmapped();
        step(1'b1, 5'd0, 8'h83, 8'h12, "unmapped_ep0");
        step(1'b1, 5'd9, 8'h83, 8'h34, "unmapped_ep9");
        step(1'b1, 5'd31, 8'h83, 8'h56, "unmapped_ep31");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] cmd = 8'($urandom);
            if ($urandom_range(0, 3) != 0) cmd[7] = 1'b0;
            tx_ready = NUM_CH'($urandom);
            rx_valid = NUM_CH'($urandom);
            rx_data  = (8*NUM_CH)'($urandom);
            step($urandom_range(0, 4) != 0, 5'($urandom_range(0, 12)), cmd,
                 8'($urandom), "random");
        end
        tx_ready = '0;
        rx_valid = '0;
    endtask

    task automatic test_async_reset();
        step(1'b1, 5'd1, 8'h01, 8'h5A, "pre_reset_push");
        rx_valid[1] = 1'b1;
        rx_data[8 +: 8] = 8'h6B;
        step(1'b0, 5'd0, 8'h00, 8'h00, "pre_reset_rx");
        rx_valid = '0;
        step(1'b1, 5'd2, 8'h00, 8'h00, "pending_status");
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (io_wreg !== 1'b0 || io_wa !== 1'b0 || io_din !== 8'h00 || io_ab_din !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset_drop got wreg=%b wa=%b din=%h ab=%h exp all 0",
                     io_wreg, io_wa, io_din, io_ab_din);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (tx_valid !== 4'h0 || rx_ready !== 4'hF) begin
            failures++;
            $display("FAIL async_reset_fifos got tx_valid=%h rx_ready=%h exp 0/F", tx_valid, rx_ready);
        end
        step(1'b1, 5'd2, 8'h00, 8'h00, "post_reset_status");
        step(1'b1, 5'd4, 8'h00, 8'h00, "post_reset_status_ch1");
    endtask

    initial begin
        reset      = 1'b1;
        io_en      = 1'b0;
        io_epnum   = '0;
        io_dout1   = '0;
        io_dout2   = '0;
        io_ab_dout = '0;
        tx_ready   = '0;
        rx_valid   = '0;
        rx_data    = '0;
        test_reset();
        test_tx_stream();
        test_tx_overflow();
        test_rx_underflow();
        test_rx_wrap();
        test_unmapped();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
